// File: rtl/sort_pipe.sv
// ============================================================================
//  Module   : sort_pipe
//  Purpose  : Pipelined odd-even transposition sorter, N lanes of W bits,
//             one vector per cycle, valid/ready with full backpressure.
//             Optional macro SORT_DESC_EN adds a per-vector descending request.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_pipe #(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_data
`ifdef SORT_DESC_EN
    ,
    input  logic           in_desc
`endif
);

    // One compare-exchange rank; pairs are disjoint so reading the input copy is safe.
    function automatic logic [N*W-1:0] cx_rank(
        input logic [N*W-1:0] d,
        input int             par,
        input logic           desc
    );
        logic [N*W-1:0] res;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           swap;
        res = d;
        for (int j = 0; j < N - 1; j++) begin
            if ((j % 2) == par) begin
                a    = d[j*W +: W];
                b    = d[(j+1)*W +: W];
                swap = desc ? (a < b) : (a > b);
                if (swap) begin
                    res[j*W +: W]     = b;
                    res[(j+1)*W +: W] = a;
                end
            end
        end
        return res;
    endfunction

    logic               w_adv;
    logic [N-1:0]       r_valid;
    logic [N*W-1:0]     r_data      [N];
    logic [N*W-1:0]     w_stage_in  [N];
    logic [N*W-1:0]     w_stage_out [N];
    logic [N-1:0]       w_desc_in;

    // Whole pipeline moves together; only a blocked output can stop it.
    assign w_adv     = !r_valid[N-1] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_valid[N-1];
    assign out_data  = r_data[N-1];

`ifdef SORT_DESC_EN
    logic [N-2:0] r_desc;

    assign w_desc_in = {r_desc, in_desc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_desc <= '0;
        end else if (w_adv) begin
            r_desc <= w_desc_in[N-2:0];
        end
    end
`else
    assign w_desc_in = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_adv) begin
            r_valid <= {r_valid[N-2:0], in_valid};
        end
    end

    generate
        for (genvar s = 0; s < N; s++) begin : g_stage
            if (s == 0) begin : g_first
                assign w_stage_in[s] = in_data;
            end else begin : g_next
                assign w_stage_in[s] = r_data[s-1];
            end

            assign w_stage_out[s] = cx_rank(w_stage_in[s], s % 2, w_desc_in[s]);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data[s] <= '0;
                end else if (w_adv) begin
                    r_data[s] <= w_stage_out[s];
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sort_pipe.sv
// ============================================================================
//  Module   : tb_sort_pipe
//  Purpose  : Self-checking bench for sort_pipe (4x4-bit and 5x8-bit instances)
//             against a queue-sort reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sort_pipe;

`ifdef SORT_DESC_EN
    localparam bit DESC_EN = 1'b1;
`else
    localparam bit DESC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_in_desc;
    logic [15:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_in_desc;
    logic [39:0] b_in_data, b_out_data;

    sort_pipe #(.W(4), .N(4)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
`ifdef SORT_DESC_EN
        ,
        .in_desc   (a_in_desc)
`endif
    );

    sort_pipe #(.W(8), .N(5)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
`ifdef SORT_DESC_EN
        ,
        .in_desc   (b_in_desc)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [63:0] a_exp[$];
    int          a_acc_cyc[$];
    bit          a_stall_prev = 1'b0;
    logic [15:0] a_prev_data  = '0;

    logic [63:0] b_exp[$];
    int          b_acc_cyc[$];
    bit          b_stall_prev = 1'b0;
    logic [39:0] b_prev_data  = '0;
    int          b_acc        = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: unpack lanes, sort the values, repack with lane 0 first.
    function automatic logic [63:0] ref_sort(input logic [63:0] d, input int n, input int w,
                                             input bit desc);
        int          q[$];
        logic [63:0] mask;
        logic [63:0] res;
        mask = (64'd1 << w) - 64'd1;
        res  = '0;
        for (int i = 0; i < n; i++) q.push_back(int'((d >> (i * w)) & mask));
        if (desc) q.rsort();
        else      q.sort();
        for (int i = 0; i < n; i++) res = res | (64'(q[i]) << (i * w));
        return res;
    endfunction

    task automatic step_a(input logic v, input logic [15:0] d, input logic dsc,
                          input logic ordy, input bit lat_chk);
        logic [63:0] e;
        int          c;
        @(negedge clk);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_desc   = dsc;
        a_out_ready = ordy;
        #1;
        if (a_stall_prev) begin
            check("a_stall_valid", a_out_valid, 1);
            check("a_stall_data", a_out_data, a_prev_data);
        end
        check("a_in_ready", a_in_ready, !(a_out_valid && !ordy));
        if (a_out_valid && ordy) begin
            if (a_exp.size() == 0) begin
                check("a_unexpected_out", a_out_valid, 0);
            end else begin
                e = a_exp.pop_front();
                c = a_acc_cyc.pop_front();
                check("a_data", a_out_data, e);
                if (lat_chk) check("a_latency", cyc - c, 4);
            end
        end
        if (v && a_in_ready) begin
            a_exp.push_back(ref_sort(d, 4, 4, DESC_EN && dsc));
            a_acc_cyc.push_back(cyc);
        end
        a_stall_prev = a_out_valid && !ordy;
        a_prev_data  = a_out_data;
        cyc++;
    endtask

    task automatic step_b(input logic v, input logic [39:0] d, input logic dsc,
                          input logic ordy, input bit lat_chk);
        logic [63:0] e;
        int          c;
        @(negedge clk);
        b_in_valid  = v;
        b_in_data   = d;
        b_in_desc   = dsc;
        b_out_ready = ordy;
        #1;
        if (b_stall_prev) begin
            check("b_stall_valid", b_out_valid, 1);
            check("b_stall_data", b_out_data, b_prev_data);
        end
        check("b_in_ready", b_in_ready, !(b_out_valid && !ordy));
        if (b_out_valid && ordy) begin
            if (b_exp.size() == 0) begin
                check("b_unexpected_out", b_out_valid, 0);
            end else begin
                e = b_exp.pop_front();
                c = b_acc_cyc.pop_front();
                check("b_data", b_out_data, e);
                if (lat_chk) check("b_latency", cyc - c, 5);
            end
        end
        if (v && b_in_ready) begin
            b_exp.push_back(ref_sort(d, 5, 8, DESC_EN && dsc));
            b_acc_cyc.push_back(cyc);
            b_acc++;
        end
        b_stall_prev = b_out_valid && !ordy;
        b_prev_data  = b_out_data;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        a_exp.delete();
        a_acc_cyc.delete();
        b_exp.delete();
        b_acc_cyc.delete();
        a_stall_prev = 1'b0;
        b_stall_prev = 1'b0;
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_b_out_data", b_out_data, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        cyc += 2;
    endtask

    task automatic drain_a(input bit lat_chk);
        for (int k = 0; k < 200 && a_exp.size() != 0; k++) step_a(0, '0, 0, 1, lat_chk);
        check("a_drain_timeout", a_exp.size(), 0);
    endtask

    task automatic drain_b();
        for (int k = 0; k < 300 && b_exp.size() != 0; k++) step_b(0, '0, 0, 1, 0);
        check("b_drain_timeout", b_exp.size(), 0);
    endtask

    initial begin
        rst         = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_in_desc   = 1'b0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_in_desc   = 1'b0;
        b_out_ready = 1'b1;
        do_reset();

        // Single vector, exact latency
        step_a(1, 16'h2413, 0, 1, 1);
        drain_a(1);

        // Sorted, reversed and all-equal keys
        step_a(1, 16'h4321, 0, 1, 1);
        step_a(1, 16'h1234, 0, 1, 1);
        step_a(1, 16'h7777, 0, 1, 1);
        drain_a(1);

        // Eight back-to-back: all out within N cycles after the last accept
        for (int k = 0; k < 8; k++) step_a(1, 16'($urandom), 0, 1, 1);
        for (int k = 0; k < 4; k++) step_a(0, '0, 0, 1, 1);
        check("t3_drained", a_exp.size(), 0);

        // Six-cycle output stall while streaming
        for (int k = 0; k < 14; k++)
            step_a(1, 16'($urandom), 0, !(k >= 2 && k < 8), 0);
        drain_a(0);

        // Reset with three vectors in flight
        for (int k = 0; k < 3; k++) step_a(1, 16'($urandom), 0, 1, 0);
        do_reset();
        for (int k = 0; k < 8; k++) step_a(0, '0, 0, 1, 0);

`ifdef SORT_DESC_EN
        step_a(1, 16'h2413, 1, 1, 1);
        step_a(1, 16'h2413, 0, 1, 1);
        drain_a(1);
`endif

        // Random traffic with random backpressure on the 4x4 instance
        for (int k = 0; k < 300; k++)
            step_a(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
                   1'($urandom_range(0, 9) < 7), 0);
        drain_a(0);

        // 5x8 instance: unstalled burst, then 1000 vectors with backpressure
        for (int k = 0; k < 10; k++)
            step_b(1, 40'({$urandom, $urandom}), 1'($urandom), 1, 1);
        drain_b();
        b_acc = 0;
        for (int k = 0; k < 6000 && b_acc < 1000; k++)
            step_b(1'($urandom_range(0, 3) != 0), 40'({$urandom, $urandom}), 1'($urandom),
                   1'($urandom_range(0, 9) < 6), 0);
        check("b_accepted", b_acc, 1000);
        drain_b();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
